// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: widths, fetch FSM states, buffer entry
// layout and the base opcodes that the main control decoder keys on.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO between the instruction memory response and
// decode. Flush wins over push/pop; simultaneous push and pop keep count.
module fetch_buffer #(
    parameter int PC_W = 32,
    parameter int I_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_pc,
    input  logic [I_W-1:0]  push_instr,
    output logic [PC_W-1:0] head_pc,
    output logic [I_W-1:0]  head_instr,
    output logic [1:0]      count
);

    logic [PC_W-1:0] pc_mem_q [2];
    logic [PC_W-1:0] pc_mem_d [2];
    logic [I_W-1:0]  instr_mem_q [2];
    logic [I_W-1:0]  instr_mem_d [2];
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [1:0]      count_q, count_d;

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = push_pc;
                instr_mem_d[wr_ptr_q] = push_instr;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: the storage is reset on purpose so the head outputs read zero out of
    // reset; a deep RAM would normally be left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign head_instr = instr_mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle-latency instruction
// memory and hands {pc, instr, opcode} to decode through valid/ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      out_opcode
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic [1:0] count;
    logic       issue;
    logic       pop;
    logic       push;
    logic [2:0] in_flight;
    logic       redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    fetch_buffer #(
        .PC_W (XLEN),
        .I_W  (32)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_pc    (req_pc_q),
        .push_instr (imem_rdata),
        .head_pc    (out_pc),
        .head_instr (out_instr),
        .count      (count)
    );

    // NOTE: sequential state uses non-blocking assignments only; every next
    // value is computed in always_comb with a default first, so no latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d  = issue ? WAIT : IDLE;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
        end
    end

    // Buffered entries plus the outstanding read must never exceed two slots.
    always_comb begin
        in_flight  = {1'b0, count} + {2'b00, state_q == WAIT};
        out_valid  = (count != 2'd0) && !redirect_valid;
        pop        = out_valid && out_ready;
        push       = (state_q == WAIT) && !redirect_valid;
        issue      = !reset && !redirect_valid && ((in_flight < 3'd2) || pop);
        imem_req   = issue;
        imem_addr  = pc_q;
        out_opcode = opcode_of(out_instr);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an address-tagged memory model and a
// scoreboard of {pc, instr} expected in issue order.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;

    int n_tests = 0;
    int n_fail  = 0;
    fetch_entry_t sb[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_opcode     (out_opcode)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0033;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard pops/pushes on the falling edge, memory answers
    // just after the rising edge with the word for the accepted address.
    task automatic tick();
        logic         req_s;
        logic [31:0]  addr_s;
        fetch_entry_t e;
        @(negedge clk);
        if (reset || redirect_valid) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_pop: observed empty scoreboard expected entry for pc %h", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_instr", out_instr, e.instr);
                check("sb_opcode", 32'(out_opcode), 32'(e.instr[6:0]));
            end
        end
        req_s  = imem_req;
        addr_s = imem_addr;
        if (req_s) sb.push_back({addr_s, word(addr_s)});
        @(posedge clk);
        #1;
        imem_rdata = req_s ? word(addr_s) : 32'hDEAD_BEEF;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        imem_rdata     = 32'h0;
        #2;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_opcode", 32'(out_opcode), 32'h0);
        tick();
        tick();

        // Streaming fetch after reset release.
        reset = 1'b0;
        #1;
        check_bit("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        check_bit("first_valid", out_valid, 1'b0);
        tick();
        check("c1_addr", imem_addr, 32'h4);
        check_bit("c1_valid", out_valid, 1'b0);
        tick();
        check_bit("c2_valid", out_valid, 1'b1);
        check("c2_pc", out_pc, 32'h0);
        check("c2_instr", out_instr, word(32'h0));
        check("c2_opcode", 32'(out_opcode), 32'(word(32'h0) & 32'h7F));
        check("c2_addr", imem_addr, 32'h8);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_bit("stream_valid", out_valid, 1'b1);
            check("stream_pc", out_pc, 32'(4 * i));
            check("stream_addr", imem_addr, 32'(8 + 4 * i));
        end

        // Back-pressure: head stable, reads stop once the buffer is full.
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_bit("stall_valid", out_valid, 1'b1);
            check("stall_pc", out_pc, 32'h10);
            check("stall_instr", out_instr, word(32'h10));
            check_bit("stall_req", imem_req, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("drain_pc0", out_pc, 32'h10);
        check_bit("drain_req", imem_req, 1'b1);
        check("drain_addr", imem_addr, 32'h18);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check("drain_pc", out_pc, 32'(16 + 4 * j));
        end

        // Redirect while the buffer holds two entries.
        out_ready = 1'b0;
        #1;
        check_bit("fill_req", imem_req, 1'b0);
        tick();
        check("full_pc", out_pc, 32'h1C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check_bit("redir_valid_mask", out_valid, 1'b0);
        check_bit("redir_no_req", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        check_bit("redir_t1_req", imem_req, 1'b1);
        check("redir_t1_addr", imem_addr, 32'h100);
        check_bit("redir_t1_valid", out_valid, 1'b0);
        tick();
        check_bit("redir_t2_valid", out_valid, 1'b0);
        check("redir_t2_addr", imem_addr, 32'h104);
        tick();
        check_bit("redir_t3_valid", out_valid, 1'b1);
        check("redir_t3_pc", out_pc, 32'h100);

        // Redirect colliding with a pop and an arriving response.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check_bit("redir2_valid_mask", out_valid, 1'b0);
        check_bit("redir2_no_req", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_bit("redir2_t1_valid", out_valid, 1'b0);
        check("redir2_t1_addr", imem_addr, 32'h200);
        tick();
        check_bit("redir2_t2_valid", out_valid, 1'b0);
        tick();
        check_bit("redir2_t3_valid", out_valid, 1'b1);
        check("redir2_t3_pc", out_pc, 32'h200);
        check("redir2_t3_instr", out_instr, word(32'h200));
        tick();
        check("redir2_t4_pc", out_pc, 32'h204);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", imem_addr, 32'h0);
        check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
        check("wrap_addr3", imem_addr, 32'h4);
        tick();
        check("wrap_pc2", out_pc, 32'h0);
        check("wrap_instr2", out_instr, word(32'h0));

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check_bit("arst_valid", out_valid, 1'b0);
        check_bit("arst_req", imem_req, 1'b0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_bit("rel_req", imem_req, 1'b1);
        check("rel_addr", imem_addr, 32'h0);
        check_bit("rel_valid0", out_valid, 1'b0);
        tick();
        check_bit("rel_valid1", out_valid, 1'b0);
        tick();
        check_bit("rel_valid2", out_valid, 1'b1);
        check("rel_pc2", out_pc, 32'h0);
        check("rel_instr2", out_instr, word(32'h0));
        tick();
        check("rel_pc3", out_pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
